// File: rtl/nlms_stream_sequencer.sv
// nlms_stream_sequencer: joins the x (reference) and d (desired) streams into
// lock-step {d, x} pairs for the NLMS core. Each pair is tagged with an adapt flag.
// The block also sequences coefficient clear, training and freeze, and it latches mu
// only at packet boundaries.
// Optional feature: define NLMS_STREAM_SEQUENCER_STATS_EN to enable sts_pair_cnt.
module nlms_stream_sequencer #(
  parameter int ITEM_W = 32,
  parameter int MU_W   = 16,
  parameter int CNT_W  = 32
) (
  input  logic                ce_clk,
  input  logic                ce_rst,
  input  logic                cfg_start,
  input  logic                cfg_stop,
  input  logic                cfg_mode,
  input  logic [CNT_W-1:0]    cfg_train_len,
  input  logic [MU_W-1:0]     cfg_mu,
  input  logic [ITEM_W-1:0]   s_x_tdata,
  input  logic                s_x_tlast,
  input  logic                s_x_tvalid,
  output logic                s_x_tready,
  input  logic [ITEM_W-1:0]   s_d_tdata,
  input  logic                s_d_tlast,
  input  logic                s_d_tvalid,
  output logic                s_d_tready,
  output logic [2*ITEM_W-1:0] m_core_tdata,
  output logic                m_core_tuser,
  output logic                m_core_tlast,
  output logic                m_core_tvalid,
  input  logic                m_core_tready,
  output logic [MU_W-1:0]     core_mu,
  output logic                core_clr_req,
  input  logic                core_clr_ack,
  output logic [1:0]          sts_state,
  output logic                sts_err,
  output logic [CNT_W-1:0]    sts_pair_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, TRAIN = 2'd2, HOLD = 2'd3} state_t;

  state_t              state, state_next;
  logic                out_valid, out_user, out_last;
  logic [2*ITEM_W-1:0] out_data;
  logic                clr_req, err, stop_pend, restart_pend, mid_pkt;
  logic [MU_W-1:0]     mu;
  logic [CNT_W-1:0]    train_cnt, train_cnt_next;
  logic                streaming, leave_req, accept, clr_done;

  // A pending stop or restart stalls new pairs once the stream sits at a packet boundary.
  assign streaming  = (state == TRAIN) || (state == HOLD);
  assign leave_req  = (stop_pend || restart_pend) && !mid_pkt;
  assign accept     = streaming && !leave_req && s_x_tvalid && s_d_tvalid &&
                      (!out_valid || m_core_tready);
  assign clr_done   = (state == CLEAR) && clr_req && core_clr_ack;
  assign s_x_tready = accept;
  assign s_d_tready = accept;

  assign m_core_tdata  = out_data;
  assign m_core_tuser  = out_user;
  assign m_core_tlast  = out_last;
  assign m_core_tvalid = out_valid;
  assign core_mu       = mu;
  assign core_clr_req  = clr_req;
  assign sts_state     = state;
  assign sts_err       = err;

  // Training count after this cycle. It counts pairs accepted in TRAIN and saturates at all-ones.
  always_comb begin
    train_cnt_next = train_cnt;
    if (accept && (state == TRAIN) && (train_cnt != '1))
      train_cnt_next = train_cnt + CNT_W'(1);
  end

  // Next-state logic. A stop takes priority over a restart, and both take priority over the freeze.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cfg_start && !cfg_stop)
          state_next = CLEAR;
      end
      CLEAR: begin
        if (stop_pend)
          state_next = IDLE;
        else if (clr_done)
          state_next = (cfg_mode && (cfg_train_len == '0)) ? HOLD : TRAIN;
      end
      TRAIN, HOLD: begin
        if (stop_pend && !mid_pkt)
          state_next = IDLE;
        else if (restart_pend && !mid_pkt)
          state_next = CLEAR;
        else if ((state == TRAIN) && cfg_mode && (train_cnt_next >= cfg_train_len))
          state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Single-entry output register. It keeps draining toward the core in every state.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      out_valid <= 1'b0;
      out_user  <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_user  <= (state == TRAIN);
      out_last  <= s_x_tlast;
      out_data  <= {s_d_tdata, s_x_tdata};
    end else if (m_core_tready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear request rises once the output register is empty and holds until the clear is acknowledged.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) clr_req <= 1'b0;
    else        clr_req <= (state == CLEAR) && (state_next == CLEAR) && (clr_req || !out_valid);
  end

  // Packet tracking, pending stop/restart, sticky error, training count and boundary-latched mu.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      stop_pend    <= 1'b0;
      restart_pend <= 1'b0;
      mid_pkt      <= 1'b0;
      err          <= 1'b0;
      train_cnt    <= '0;
      mu           <= '0;
    end else begin
      if (state == IDLE)   stop_pend <= 1'b0;
      else if (cfg_stop)   stop_pend <= 1'b1;
      if (!streaming)                  restart_pend <= 1'b0;
      else if (cfg_start && !cfg_stop) restart_pend <= 1'b1;
      if (accept) mid_pkt <= !s_x_tlast;
      if (clr_done) begin
        err       <= 1'b0;
        train_cnt <= '0;
        mu        <= cfg_mu;
      end else begin
        if (accept && (s_x_tlast != s_d_tlast)) err <= 1'b1;
        train_cnt <= train_cnt_next;
        if (accept && s_x_tlast) mu <= cfg_mu;
      end
    end
  end

`ifdef NLMS_STREAM_SEQUENCER_STATS_EN
  logic [CNT_W-1:0] pair_cnt;

  // Free-running count of accepted pairs. It wraps naturally and only reset clears it.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst)      pair_cnt <= '0;
    else if (accept) pair_cnt <= pair_cnt + CNT_W'(1);
  end

  assign sts_pair_cnt = pair_cnt;
`else
  assign sts_pair_cnt = '0;
`endif

endmodule

// File: tb/tb_nlms_stream_sequencer.sv
// tb_nlms_stream_sequencer: directed bench for nlms_stream_sequencer.
// Expected beats, adapt flags and mu values are derived from the packet index and the configured mode.
module tb_nlms_stream_sequencer;

  localparam int ITEM_W = 32;
  localparam int MU_W   = 16;
  localparam int CNT_W  = 32;

  logic                ce_clk, ce_rst;
  logic                cfg_start, cfg_stop, cfg_mode;
  logic [CNT_W-1:0]    cfg_train_len;
  logic [MU_W-1:0]     cfg_mu;
  logic [ITEM_W-1:0]   s_x_tdata, s_d_tdata;
  logic                s_x_tlast, s_x_tvalid, s_x_tready;
  logic                s_d_tlast, s_d_tvalid, s_d_tready;
  logic [2*ITEM_W-1:0] m_core_tdata;
  logic                m_core_tuser, m_core_tlast, m_core_tvalid, m_core_tready;
  logic [MU_W-1:0]     core_mu;
  logic                core_clr_req, core_clr_ack;
  logic [1:0]          sts_state;
  logic                sts_err;
  logic [CNT_W-1:0]    sts_pair_cnt;

  int              n_cmp = 0;
  int              n_err = 0;
  logic [MU_W-1:0] exp_mu;
  logic            exp_mode;
  int              exp_len;
  int              beats_since_clr;

  nlms_stream_sequencer #(.ITEM_W(ITEM_W), .MU_W(MU_W), .CNT_W(CNT_W)) dut (
    .ce_clk(ce_clk), .ce_rst(ce_rst),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_mode(cfg_mode),
    .cfg_train_len(cfg_train_len), .cfg_mu(cfg_mu),
    .s_x_tdata(s_x_tdata), .s_x_tlast(s_x_tlast), .s_x_tvalid(s_x_tvalid), .s_x_tready(s_x_tready),
    .s_d_tdata(s_d_tdata), .s_d_tlast(s_d_tlast), .s_d_tvalid(s_d_tvalid), .s_d_tready(s_d_tready),
    .m_core_tdata(m_core_tdata), .m_core_tuser(m_core_tuser), .m_core_tlast(m_core_tlast),
    .m_core_tvalid(m_core_tvalid), .m_core_tready(m_core_tready),
    .core_mu(core_mu), .core_clr_req(core_clr_req), .core_clr_ack(core_clr_ack),
    .sts_state(sts_state), .sts_err(sts_err), .sts_pair_cnt(sts_pair_cnt)
  );

  initial ce_clk = 1'b0;
  always #5 ce_clk = ~ce_clk;

  function automatic logic [31:0] xval(input int seed, input int i);
    return 32'hA500_0000 + 32'(seed << 12) + 32'(i);
  endfunction

  function automatic logic [31:0] dval(input int seed, input int i);
    return 32'h5A00_0000 + 32'(seed << 12) + 32'(i);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Start (or restart) a sequence and acknowledge the clear five cycles after the request appears.
  task automatic startSequence(input logic mode, input int len, input logic [MU_W-1:0] mu);
    int cyc;
    cfg_mode = mode;
    cfg_train_len = CNT_W'(len);
    cfg_mu = mu;
    s_x_tvalid = 1'b0;
    s_d_tvalid = 1'b0;
    m_core_tready = 1'b1;
    cfg_start = 1'b1;
    @(posedge ce_clk); #1;
    cfg_start = 1'b0;
    cyc = 0;
    while (!core_clr_req && cyc < 20) begin
      @(posedge ce_clk); #1;
      cyc++;
    end
    checkOutput("clr_req_rise", 64'(core_clr_req), 64'd1);
    checkOutput("state_clear", 64'(sts_state), 64'd1);
    repeat (5) @(posedge ce_clk);
    #1;
    checkOutput("clr_req_held", 64'(core_clr_req), 64'd1);
    core_clr_ack = 1'b1;
    @(posedge ce_clk); #1;
    core_clr_ack = 1'b0;
    checkOutput("state_after_clear", 64'(sts_state), (mode && len == 0) ? 64'd3 : 64'd2);
    checkOutput("clr_req_drop", 64'(core_clr_req), 64'd0);
    checkOutput("mu_on_clear", 64'(core_mu), 64'(mu));
    checkOutput("err_cleared", 64'(sts_err), 64'd0);
    exp_mu = mu;
    exp_mode = mode;
    exp_len = len;
    beats_since_clr = 0;
  endtask

  // Stream one n-sample packet and check each core beat against the expected pair sequence.
  task automatic applyStimulus(input int seed, input int n, input int dper, input bit stall,
                               input int dlast, input int stop_idx, input int mu_idx,
                               input logic [MU_W-1:0] mu_new);
    int i, beats, cyc, tsplit, derr, lerr, uerr, muerr;
    bit stop_sent, mu_load, acc, uexp;
    logic [MU_W-1:0] mu_next;
    i = 0; beats = 0; cyc = 0; tsplit = 0; derr = 0; lerr = 0; uerr = 0; muerr = 0;
    stop_sent = 0; mu_next = '0;
    while (beats < n && cyc < 4000) begin
      if (i == mu_idx) cfg_mu = mu_new;
      cfg_stop = (i == stop_idx) && !stop_sent;
      if (cfg_stop) stop_sent = 1;
      s_x_tvalid = (i < n) && (!stall || $urandom_range(3) != 0);
      s_d_tvalid = (i < n) && ((cyc % dper) == 0) && (!stall || $urandom_range(3) != 0);
      s_x_tdata  = (i < n) ? xval(seed, i) : '0;
      s_d_tdata  = (i < n) ? dval(seed, i) : '0;
      s_x_tlast  = (i == n - 1);
      s_d_tlast  = (i == dlast);
      m_core_tready = !stall || $urandom_range(3) != 0;
      #4;
      if (s_x_tready !== s_d_tready) tsplit++;
      if (core_mu !== exp_mu) muerr++;
      if (m_core_tvalid && m_core_tready) begin
        uexp = !exp_mode || (beats_since_clr < exp_len);
        if (m_core_tdata !== {dval(seed, beats), xval(seed, beats)}) derr++;
        if (m_core_tlast !== (beats == n - 1)) lerr++;
        if (m_core_tuser !== uexp) uerr++;
        beats++;
        beats_since_clr++;
      end
      acc = s_x_tready && s_d_tready && s_x_tvalid && s_d_tvalid;
      mu_load = acc && s_x_tlast;
      if (mu_load) mu_next = cfg_mu;
      if (acc) i++;
      @(posedge ce_clk); #1;
      if (mu_load) exp_mu = mu_next;
      cfg_stop = 1'b0;
      cyc++;
    end
    s_x_tvalid = 1'b0;
    s_d_tvalid = 1'b0;
    s_x_tlast = 1'b0;
    s_d_tlast = 1'b0;
    m_core_tready = 1'b1;
    checkOutput("beat_count", 64'(beats), 64'(n));
    checkOutput("pairs_accepted", 64'(i), 64'(n));
    checkOutput("data_errors", 64'(derr), 64'd0);
    checkOutput("tlast_errors", 64'(lerr), 64'd0);
    checkOutput("tuser_errors", 64'(uerr), 64'd0);
    checkOutput("tready_split", 64'(tsplit), 64'd0);
    checkOutput("mu_timing_errors", 64'(muerr), 64'd0);
  endtask

  initial begin
    ce_rst = 1'b1;
    cfg_start = 0; cfg_stop = 0; cfg_mode = 0; cfg_train_len = '0; cfg_mu = '0;
    s_x_tdata = '0; s_x_tlast = 0; s_x_tvalid = 0;
    s_d_tdata = '0; s_d_tlast = 0; s_d_tvalid = 0;
    m_core_tready = 0; core_clr_ack = 0;
    exp_mu = '0; exp_mode = 0; exp_len = 0; beats_since_clr = 0;

    // Reset values
    @(posedge ce_clk); #1;
    checkOutput("rst_state", 64'(sts_state), 64'd0);
    checkOutput("rst_tvalid", 64'(m_core_tvalid), 64'd0);
    checkOutput("rst_tuser_tlast", 64'({m_core_tuser, m_core_tlast}), 64'd0);
    checkOutput("rst_treadys", 64'({s_x_tready, s_d_tready}), 64'd0);
    checkOutput("rst_clr_req", 64'(core_clr_req), 64'd0);
    checkOutput("rst_err", 64'(sts_err), 64'd0);
    checkOutput("rst_mu", 64'(core_mu), 64'd0);
    checkOutput("rst_pair_cnt", 64'(sts_pair_cnt), 64'd0);
    ce_rst = 1'b0;
    @(posedge ce_clk); #1;

    // Mode 0: every pair adapts; mu moves only after the tlast pair of the packet where it changed
    startSequence(1'b0, 0, 16'h0100);
    applyStimulus(1, 64, 1, 1'b1, 63, -1, -1, 16'h0100);
    applyStimulus(2, 64, 1, 1'b1, 63, -1, 10, 16'h0200);
    checkOutput("mu_after_packet", 64'(core_mu), 64'h0200);
    applyStimulus(3, 64, 3, 1'b0, 63, -1, -1, 16'h0200);

    // Mode 1, train_len 100: beats 1..100 adapt, then freeze
    startSequence(1'b1, 100, 16'h0300);
    applyStimulus(4, 64, 1, 1'b0, 63, -1, -1, 16'h0300);
    checkOutput("state_train_mid", 64'(sts_state), 64'd2);
    applyStimulus(5, 64, 1, 1'b0, 63, -1, -1, 16'h0300);
    checkOutput("state_hold", 64'(sts_state), 64'd3);

    // Stop at sample 20: the packet completes, then IDLE with treadys held low
    applyStimulus(6, 64, 1, 1'b0, 63, 20, -1, 16'h0300);
    s_x_tvalid = 1'b1; s_d_tvalid = 1'b1;
    repeat (2) @(posedge ce_clk);
    #1;
    checkOutput("state_idle_after_stop", 64'(sts_state), 64'd0);
    checkOutput("idle_treadys", 64'({s_x_tready, s_d_tready}), 64'd0);
    s_x_tvalid = 1'b0; s_d_tvalid = 1'b0;
    cfg_start = 1'b1; cfg_stop = 1'b1;
    @(posedge ce_clk); #1;
    cfg_start = 1'b0; cfg_stop = 1'b0;
    repeat (2) @(posedge ce_clk);
    #1;
    checkOutput("start_stop_same_cycle", 64'(sts_state), 64'd0);

    // tlast mismatch (d ends one sample early) sets a sticky error
    startSequence(1'b0, 0, 16'h0400);
    applyStimulus(7, 64, 1, 1'b0, 62, -1, -1, 16'h0400);
    checkOutput("err_set", 64'(sts_err), 64'd1);
    applyStimulus(8, 64, 1, 1'b0, 63, -1, -1, 16'h0400);
    checkOutput("err_sticky", 64'(sts_err), 64'd1);

    // Mode 0 -> 1 mid-TRAIN with the count already past train_len freezes on the next cycle
    cfg_train_len = CNT_W'(50);
    cfg_mode = 1'b1;
    @(posedge ce_clk); #1;
    checkOutput("mode_switch_hold", 64'(sts_state), 64'd3);

    // train_len 0 in mode 1 goes straight to HOLD; the clear also drops the sticky error
    startSequence(1'b1, 0, 16'h0500);

    // Asynchronous reset mid-transfer drops the output beat immediately
    s_x_tdata = xval(9, 0); s_d_tdata = dval(9, 0);
    s_x_tvalid = 1'b1; s_d_tvalid = 1'b1; m_core_tready = 1'b0;
    @(posedge ce_clk); #1;
    checkOutput("tvalid_before_rst", 64'(m_core_tvalid), 64'd1);
    #2 ce_rst = 1'b1;
    #1;
    checkOutput("async_rst_tvalid", 64'(m_core_tvalid), 64'd0);
    checkOutput("async_rst_state", 64'(sts_state), 64'd0);
    checkOutput("async_rst_mu", 64'(core_mu), 64'd0);
    s_x_tvalid = 1'b0; s_d_tvalid = 1'b0;
    @(posedge ce_clk); #1;
    ce_rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nlms_stream_sequencer.md
Name: nlms_stream_sequencer

Overview:
- Control and scheduling block in the ce_clk domain of the NLMS RFNoC block, between the two input sample streams (reference x on input port 0, desired d on input port 1) and the HLS NLMS core.
- Joins x/d into lock-step sample pairs and tags each pair with an adapt flag.
- Sequences coefficient clear, training window and freeze; latches step size mu only at packet boundaries.

Parameters:
- ITEM_W, 32, sample width (sc16) of x, d and core data.
- MU_W, 16, step-size width.
- CNT_W, 32, training-length and counter width.

Ports:
- ce_clk  in  1  block clock
- ce_rst  in  1  asynchronous active-high reset
- cfg_start  in  1  pulse: begin sequence
- cfg_stop  in  1  pulse: return to IDLE at packet boundary
- cfg_mode  in  1  0 = adapt always, 1 = train then freeze
- cfg_train_len  in  CNT_W  number of adapting pairs in mode 1
- cfg_mu  in  MU_W  requested step size
- s_x_tdata/s_x_tlast/s_x_tvalid/s_x_tready  in,in,in,out  ITEM_W,1,1,1  reference stream
- s_d_tdata/s_d_tlast/s_d_tvalid/s_d_tready  in,in,in,out  ITEM_W,1,1,1  desired stream
- m_core_tdata  out  2*ITEM_W  {d, x}, x in LSBs
- m_core_tuser  out  1  adapt flag for this beat
- m_core_tlast/m_core_tvalid  out  1,1  core stream framing/valid
- m_core_tready  in  1  core ready
- core_mu  out  MU_W  step size to core
- core_clr_req  out  1  coefficient-clear request
- core_clr_ack  in  1  one-cycle clear-done pulse
- sts_state  out  2  FSM state
- sts_err  out  1  sticky tlast-mismatch flag
- sts_pair_cnt  out  CNT_W  accepted pairs (optional feature)

Behaviour:
- Reset: state IDLE; all tready, m_core_tvalid, m_core_tuser, m_core_tlast, core_clr_req and sts_err = 0; core_mu = 0; counters = 0.
- States: IDLE=0, CLEAR=1, TRAIN=2, HOLD=3.
- IDLE: both treadys low. On cfg_start -> CLEAR.
- CLEAR:
  - Wait until the output register is empty, then assert core_clr_req; hold it until core_clr_ack.
  - On ack: clear the training counter, latch core_mu = cfg_mu, clear sts_err.
  - Next state: HOLD if mode 1 and cfg_train_len = 0; otherwise TRAIN.
- TRAIN/HOLD join:
  - Pair accepted when s_x_tvalid & s_d_tvalid & (output register empty | m_core_tready).
  - s_x_tready = s_d_tready = that condition; both asserted in the same cycle, never one alone.
  - Single output register: latency 1 cycle, full throughput.
  - Output beat: m_core_tlast = s_x_tlast; m_core_tuser = 1 in TRAIN, 0 in HOLD.
  - If s_x_tlast != s_d_tlast on an accepted pair, set sts_err (sticky until next CLEAR).
- Training count:
  - Mode 1: the count increments per accepted pair in TRAIN. The pair that makes count = cfg_train_len carries adapt = 1, and the state moves to HOLD next cycle.
  - Mode 0: TRAIN persists; the counter saturates at all-ones.
- mu update: core_mu reloads from cfg_mu only on the cycle a tlast pair is accepted, or on CLEAR exit. It never changes mid-packet.
- cfg_start in TRAIN/HOLD: treated as stop-then-start. Wait for the packet boundary, then -> CLEAR.
- cfg_stop:
  - Sets a pending flag. Go to IDLE when not mid-packet; mid-packet means a pair has been accepted since the last tlast.
  - The output register still drains in IDLE.
  - cfg_stop and cfg_start in the same cycle: stop wins.
- Mode 0 -> 1 change mid-TRAIN: takes effect immediately against the current count. If count >= cfg_train_len, go to HOLD next cycle.
- Reset mid-transfer: output dropped immediately; core_clr_req deasserts.

Optional Feature:
- Macro: NLMS_STREAM_SEQUENCER_STATS_EN.
- Defined: sts_pair_cnt counts every accepted pair in any state. It wraps at 2^CNT_W and is cleared on reset only.
- Undefined: sts_pair_cnt is tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset, then pulse cfg_start with mode 0, mu=0x0100; ack clear after 5 cycles; send 64-sample packets on x and d with random stalls -> 64 core beats per packet, all tuser=1, data {d,x} in order, core_mu=0x0100.
- Mode 1, train_len=100, two 64-sample packets -> beats 1..100 tuser=1, beats 101..128 tuser=0, sts_state=3 after beat 100.
- x valid continuously, d valid every 3rd cycle -> both treadys only assert together; exactly one core beat per d beat; no sample lost or duplicated.
- cfg_mu changed 0x0100 -> 0x0200 at sample 10 of a packet -> core_mu changes in the cycle after that packet's tlast accept, not before.
- cfg_stop at sample 20 of 64 -> remaining 44 pairs forwarded, then IDLE with treadys 0. Then cfg_start and cfg_stop in the same cycle -> state stays IDLE.
- d tlast at sample 63 while x tlast at 64 -> sts_err=1, held until next CLEAR. Then assert ce_rst mid-packet -> m_core_tvalid=0 and state=0 in the same cycle (async).
